mlp_result_collector: RTL and testbench
=======================================

MLP_RESULT_COLLECTOR -- requirements
Module: mlp_result_collector

Interface
REQ-001 SHALL have parameter DIGIT_W, default 4, bits per classification result.
REQ-002 SHALL have parameter MAX_SAMPLES, default 32, LCD buffer depth in results.
REQ-003 SHALL have parameter CNT_W, default 8, width of sample and correct counters.
REQ-004 SHALL have port s_axi_aclk  in  1  the single clock; all state on rising edge.
REQ-005 SHALL have port s_axi_aresetn  in  1  asynchronous active-low reset.
REQ-006 SHALL have port start  in  1  one-cycle request to begin a run.
REQ-007 SHALL have port abort  in  1  synchronous run cancel.
REQ-008 SHALL have port mode  in  1  0 = single pass, 1 = continuous; sampled at start.
REQ-009 SHALL have port num_samples  in  8  requested samples per pass; sampled at start.
REQ-010 SHALL have port result_valid  in  1  MLP result present.
REQ-011 SHALL have port result_data  in  DIGIT_W  MLP classified digit.
REQ-012 SHALL have port result_ready  out  1  collector accepts a result.
REQ-013 SHALL have port exp_addr  out  CNT_W  expected-label ROM address.
REQ-014 SHALL have port exp_data  in  DIGIT_W  expected label, valid 1 cycle after exp_addr.
REQ-015 SHALL have port lcd_output  out  MAX_SAMPLES*DIGIT_W  packed results, slot i at [i*DIGIT_W +: DIGIT_W].
REQ-016 SHALL have port sample_count  out  CNT_W  results accepted this pass.
REQ-017 SHALL have port correct_count  out  CNT_W  matches this pass.
REQ-018 SHALL have port last_correct  out  CNT_W  correct_count of last completed pass.
REQ-019 SHALL have port busy  out  1  high outside IDLE and DONE.
REQ-020 SHALL have port done  out  1  high in DONE until next start.

Function
REQ-021 SHALL implement states IDLE, FETCH, COLLECT, DONE.
REQ-022 SHALL, on start in IDLE or DONE, load N = min(num_samples, MAX_SAMPLES), latch mode, clear idx, lcd_output, sample_count, correct_count, and enter FETCH next cycle.
REQ-023 SHALL, if N = 0 at start, go directly to DONE with last_correct = 0.
REQ-024 SHALL ignore start while busy.
REQ-025 SHALL drive exp_addr = idx (registered) in every state.
REQ-026 SHALL stay in FETCH exactly one cycle, then enter COLLECT.
REQ-027 SHALL assert result_ready only in COLLECT; a transfer occurs when result_valid && result_ready.
REQ-028 SHALL, on transfer, write result_data to slot idx, increment sample_count, increment correct_count iff result_data == exp_data, and return to FETCH with idx+1.
REQ-029 SHALL hold COLLECT with no state change while result_valid is low.
REQ-030 SHALL, on transfer with idx = N-1 and mode 0, load last_correct with the updated correct_count and enter DONE.
REQ-031 SHALL, on transfer with idx = N-1 and mode 1, load last_correct, wrap idx to 0, clear sample_count and correct_count, keep lcd_output (slots overwritten in place), and enter FETCH.
REQ-032 SHALL saturate counters at 2^CNT_W-1.
REQ-033 SHALL, on abort while busy, enter IDLE next cycle holding lcd_output and counts; abort has priority over a same-cycle transfer (result discarded); abort in IDLE or DONE has no effect.
REQ-034 SHALL give minimum throughput of one result per 2 cycles.

Reset
REQ-035 SHALL, while s_axi_aresetn = 0, force state IDLE, idx, counters, last_correct, lcd_output, exp_addr to 0 and result_ready, busy, done to 0 immediately, independent of the clock.
REQ-036 SHALL, on reset assertion mid-run, discard the run with no partial update after release.

Verification
REQ-037 SHALL test: start, mode 0, N=4, ROM {1,2,3,4}, results {1,2,7,4} valid every cycle -> lcd slots 0-3 = 1,2,7,4, correct_count = 3, last_correct = 3, done = 1, first result_ready 2 cycles after start.
REQ-038 SHALL test: num_samples = 200, MAX_SAMPLES = 32 -> exactly 32 transfers then DONE, sample_count = 32.
REQ-039 SHALL test: num_samples = 0 -> done = 1 one cycle after start, no result_ready pulse.
REQ-040 SHALL test: mode 1, N=2, 5 matching results -> last_correct = 2 after 2nd and 4th transfers, idx wraps to 0, busy stays 1.
REQ-041 SHALL test: abort in same cycle as a transfer at idx 1 -> IDLE next cycle, sample_count = 1, slot 1 unchanged.
REQ-042 SHALL test: s_axi_aresetn low mid-COLLECT between clock edges -> all outputs 0 before next edge.

Source files
------------

// File: rtl/mlp_result_collector.sv
// rtl/mlp_result_collector.sv - collects MLP classification results, scores them against
// an expected-label ROM and packs them for an LCD, in single-pass or continuous runs.
module mlp_result_collector #(
  parameter int DIGIT_W     = 4,
  parameter int MAX_SAMPLES = 32,
  parameter int CNT_W       = 8
) (
  input  logic                           s_axi_aclk,
  input  logic                           s_axi_aresetn,
  input  logic                           start,
  input  logic                           abort,
  input  logic                           mode,
  input  logic [7:0]                     num_samples,
  input  logic                           result_valid,
  input  logic [DIGIT_W-1:0]             result_data,
  output logic                           result_ready,
  output logic [CNT_W-1:0]               exp_addr,
  input  logic [DIGIT_W-1:0]             exp_data,
  output logic [MAX_SAMPLES*DIGIT_W-1:0] lcd_output,
  output logic [CNT_W-1:0]               sample_count,
  output logic [CNT_W-1:0]               correct_count,
  output logic [CNT_W-1:0]               last_correct,
  output logic                           busy,
  output logic                           done
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_COLLECT = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int               LCD_W   = MAX_SAMPLES * DIGIT_W;
  localparam logic [7:0]       MAX_N   = 8'(MAX_SAMPLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t             state_q, state_d;
  logic [7:0]         idx_q, idx_d;
  logic [7:0]         n_q, n_d;
  logic               mode_q, mode_d;
  logic [LCD_W-1:0]   lcd_q, lcd_d;
  logic [CNT_W-1:0]   sample_q, sample_d;
  logic [CNT_W-1:0]   correct_q, correct_d;
  logic [CNT_W-1:0]   last_q, last_d;

  logic [7:0]         n_start;
  logic [CNT_W-1:0]   sample_inc;
  logic [CNT_W-1:0]   correct_upd;
  logic               last_slot;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    n_d         = n_q;
    mode_d      = mode_q;
    lcd_d       = lcd_q;
    sample_d    = sample_q;
    correct_d   = correct_q;
    last_d      = last_q;
    n_start     = (num_samples > MAX_N) ? MAX_N : num_samples;
    sample_inc  = (sample_q == CNT_MAX) ? sample_q : sample_q + CNT_ONE;
    correct_upd = correct_q;
    if (result_data == exp_data && correct_q != CNT_MAX) begin
      correct_upd = correct_q + CNT_ONE;
    end
    last_slot   = (idx_q == n_q - 8'd1);

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          n_d       = n_start;
          mode_d    = mode;
          idx_d     = 8'd0;
          lcd_d     = '0;
          sample_d  = '0;
          correct_d = '0;
          if (n_start == 8'd0) begin
            last_d  = '0;
            state_d = ST_DONE;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end

      // One cycle here lets the ROM present exp_data for the current idx.
      ST_FETCH: begin
        state_d = abort ? ST_IDLE : ST_COLLECT;
      end

      ST_COLLECT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (result_valid) begin
          for (int i = 0; i < MAX_SAMPLES; i++) begin
            if (idx_q == 8'(i)) begin
              lcd_d[i*DIGIT_W +: DIGIT_W] = result_data;
            end
          end
          sample_d  = sample_inc;
          correct_d = correct_upd;
          if (last_slot) begin
            last_d = correct_upd;
            if (mode_q) begin
              // Continuous mode keeps the LCD image and overwrites slots in place.
              idx_d     = 8'd0;
              sample_d  = '0;
              correct_d = '0;
              state_d   = ST_FETCH;
            end else begin
              state_d   = ST_DONE;
            end
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = ST_FETCH;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q   <= ST_IDLE;
      idx_q     <= 8'd0;
      n_q       <= 8'd0;
      mode_q    <= 1'b0;
      lcd_q     <= '0;
      sample_q  <= '0;
      correct_q <= '0;
      last_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      n_q       <= n_d;
      mode_q    <= mode_d;
      lcd_q     <= lcd_d;
      sample_q  <= sample_d;
      correct_q <= correct_d;
      last_q    <= last_d;
    end
  end

  assign result_ready  = (state_q == ST_COLLECT);
  assign busy          = (state_q == ST_FETCH) || (state_q == ST_COLLECT);
  assign done          = (state_q == ST_DONE);
  assign exp_addr      = CNT_W'(idx_q);
  assign lcd_output    = lcd_q;
  assign sample_count  = sample_q;
  assign correct_count = correct_q;
  assign last_correct  = last_q;

endmodule

// File: tb/tb_mlp_result_collector.sv
// tb/tb_mlp_result_collector.sv - directed-vector bench for mlp_result_collector with a
// registered expected-label ROM model.
module tb_mlp_result_collector;

  logic         clk;
  logic         rstn;
  logic         start;
  logic         abort;
  logic         mode;
  logic [7:0]   num_samples;
  logic         result_valid;
  logic [3:0]   result_data;
  logic         result_ready;
  logic [7:0]   exp_addr;
  logic [3:0]   exp_data;
  logic [127:0] lcd_output;
  logic [7:0]   sample_count;
  logic [7:0]   correct_count;
  logic [7:0]   last_correct;
  logic         busy;
  logic         done;

  logic [3:0] rom [0:255];
  logic [3:0] res [0:63];
  int vecs;
  int errs;

  mlp_result_collector #(.DIGIT_W(4), .MAX_SAMPLES(32), .CNT_W(8)) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rstn),
    .start         (start),
    .abort         (abort),
    .mode          (mode),
    .num_samples   (num_samples),
    .result_valid  (result_valid),
    .result_data   (result_data),
    .result_ready  (result_ready),
    .exp_addr      (exp_addr),
    .exp_data      (exp_data),
    .lcd_output    (lcd_output),
    .sample_count  (sample_count),
    .correct_count (correct_count),
    .last_correct  (last_correct),
    .busy          (busy),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) exp_data <= rom[exp_addr];

  function automatic logic [3:0] slot(input int i);
    return lcd_output[i*4 +: 4];
  endfunction

  // Starts a pass at the next negedge and streams res[] with valid held high until done.
  task automatic run_pass(input logic m, input logic [7:0] ns, input int budget,
                          output int xfers, output int first_ready, output int done_cyc);
    bit pend;
    pend = 0;
    xfers = 0;
    first_ready = -1;
    done_cyc = -1;
    @(negedge clk);
    start = 1; mode = m; num_samples = ns;
    result_valid = 1; result_data = res[0];
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      start = 0;
      if (pend) begin
        xfers++;
        pend = 0;
        if (xfers < 64) result_data = res[xfers];
      end
      if (done) begin
        done_cyc = c;
        break;
      end
      if (result_ready) begin
        if (first_ready < 0) first_ready = c;
        pend = 1;
      end
    end
    result_valid = 0;
  endtask

  task automatic test_reset;
    rstn = 0; start = 0; abort = 0; mode = 0; num_samples = 0;
    result_valid = 0; result_data = 0;
    #2;
    vecs++; if (busy !== 1'b0 || done !== 1'b0 || result_ready !== 1'b0) begin
      errs++; $display("FAIL reset_flags: got busy=%b done=%b ready=%b want 0 0 0", busy, done, result_ready); end
    vecs++; if (lcd_output !== 128'd0 || sample_count !== 8'd0 || correct_count !== 8'd0 || last_correct !== 8'd0 || exp_addr !== 8'd0) begin
      errs++; $display("FAIL reset_regs: got lcd=%h sc=%0d cc=%0d lc=%0d addr=%0d want all 0", lcd_output, sample_count, correct_count, last_correct, exp_addr); end
    repeat (2) @(negedge clk);
    rstn = 1;
    @(negedge clk);
    vecs++; if (busy !== 1'b0 || done !== 1'b0) begin
      errs++; $display("FAIL idle_after_reset: got busy=%b done=%b want 0 0", busy, done); end
  endtask

  task automatic test_single_pass;
    int x, fr, dc;
    rom[0] = 1; rom[1] = 2; rom[2] = 3; rom[3] = 4;
    res[0] = 1; res[1] = 2; res[2] = 7; res[3] = 4;
    run_pass(1'b0, 8'd4, 40, x, fr, dc);
    vecs++; if (fr !== 2) begin errs++; $display("FAIL first_ready_latency: got %0d want 2", fr); end
    vecs++; if (dc !== 9) begin errs++; $display("FAIL done_cycle: got %0d want 9", dc); end
    vecs++; if (x !== 4) begin errs++; $display("FAIL single_xfers: got %0d want 4", x); end
    vecs++; if (slot(0) !== 4'd1 || slot(1) !== 4'd2 || slot(2) !== 4'd7 || slot(3) !== 4'd4) begin
      errs++; $display("FAIL single_slots: got %0d %0d %0d %0d want 1 2 7 4", slot(0), slot(1), slot(2), slot(3)); end
    vecs++; if (correct_count !== 8'd3) begin errs++; $display("FAIL single_correct: got %0d want 3", correct_count); end
    vecs++; if (last_correct !== 8'd3) begin errs++; $display("FAIL single_last_correct: got %0d want 3", last_correct); end
    vecs++; if (sample_count !== 8'd4) begin errs++; $display("FAIL single_samples: got %0d want 4", sample_count); end
    vecs++; if (done !== 1'b1 || busy !== 1'b0) begin errs++; $display("FAIL single_done: got done=%b busy=%b want 1 0", done, busy); end
  endtask

  task automatic test_clamp;
    int x, fr, dc;
    for (int i = 0; i < 256; i++) rom[i] = 4'(i);
    for (int i = 0; i < 64; i++) res[i] = 4'(i);
    run_pass(1'b0, 8'd200, 200, x, fr, dc);
    vecs++; if (x !== 32) begin errs++; $display("FAIL clamp_xfers: got %0d want 32", x); end
    vecs++; if (dc !== 65) begin errs++; $display("FAIL clamp_done_cycle: got %0d want 65", dc); end
    vecs++; if (sample_count !== 8'd32) begin errs++; $display("FAIL clamp_samples: got %0d want 32", sample_count); end
    vecs++; if (last_correct !== 8'd32) begin errs++; $display("FAIL clamp_last_correct: got %0d want 32", last_correct); end
    vecs++; if (slot(31) !== 4'd15 || slot(17) !== 4'd1) begin
      errs++; $display("FAIL clamp_slots: got s31=%0d s17=%0d want 15 1", slot(31), slot(17)); end
  endtask

  task automatic test_zero_samples;
    @(negedge clk);
    start = 1; mode = 0; num_samples = 0;
    @(negedge clk);
    start = 0;
    vecs++; if (done !== 1'b1 || busy !== 1'b0) begin errs++; $display("FAIL zero_done: got done=%b busy=%b want 1 0", done, busy); end
    vecs++; if (last_correct !== 8'd0) begin errs++; $display("FAIL zero_last_correct: got %0d want 0", last_correct); end
    for (int c = 0; c < 3; c++) begin
      vecs++; if (result_ready !== 1'b0) begin errs++; $display("FAIL zero_no_ready: got %b want 0 at cycle %0d", result_ready, c); end
      @(negedge clk);
    end
    vecs++; if (lcd_output !== 128'd0 || sample_count !== 8'd0) begin
      errs++; $display("FAIL zero_cleared: got lcd=%h sc=%0d want 0 0", lcd_output, sample_count); end
  endtask

  task automatic test_continuous;
    int x;
    bit pend;
    x = 0; pend = 0;
    rom[0] = 5; rom[1] = 6;
    for (int i = 0; i < 8; i++) res[i] = (i % 2) ? 4'd6 : 4'd5;
    @(negedge clk);
    start = 1; mode = 1; num_samples = 2; result_valid = 1; result_data = res[0];
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = 0;
      if (c > 1) begin
        vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL cont_busy: got %b want 1 at cycle %0d", busy, c); end
      end
      if (pend) begin
        x++;
        pend = 0;
        result_data = res[x];
        if (x == 2 || x == 4) begin
          vecs++; if (last_correct !== 8'd2) begin errs++; $display("FAIL cont_last_correct: got %0d want 2 after xfer %0d", last_correct, x); end
          vecs++; if (exp_addr !== 8'd0 || sample_count !== 8'd0) begin
            errs++; $display("FAIL cont_wrap: got addr=%0d sc=%0d want 0 0 after xfer %0d", exp_addr, sample_count, x); end
        end
        if (x == 5) begin
          result_valid = 0;
          break;
        end
      end
      if (result_ready) pend = 1;
    end
    vecs++; if (x !== 5) begin errs++; $display("FAIL cont_xfers: got %0d want 5", x); end
    vecs++; if (sample_count !== 8'd1 || correct_count !== 8'd1 || exp_addr !== 8'd1) begin
      errs++; $display("FAIL cont_fifth: got sc=%0d cc=%0d addr=%0d want 1 1 1", sample_count, correct_count, exp_addr); end
    abort = 1;
    @(negedge clk);
    abort = 0;
    vecs++; if (busy !== 1'b0 || done !== 1'b0) begin errs++; $display("FAIL cont_abort_idle: got busy=%b done=%b want 0 0", busy, done); end
    vecs++; if (slot(0) !== 4'd5 || slot(1) !== 4'd6 || sample_count !== 8'd1) begin
      errs++; $display("FAIL cont_abort_hold: got s0=%0d s1=%0d sc=%0d want 5 6 1", slot(0), slot(1), sample_count); end
  endtask

  task automatic test_abort_transfer;
    int x;
    bit pend, hit;
    x = 0; pend = 0; hit = 0;
    rom[0] = 1; rom[1] = 2; rom[2] = 3; rom[3] = 4;
    res[0] = 1; res[1] = 9; res[2] = 3; res[3] = 4;
    @(negedge clk);
    start = 1; mode = 0; num_samples = 4; result_valid = 1; result_data = res[0];
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = 0;
      if (pend) begin
        x++;
        pend = 0;
        result_data = res[x];
      end
      if (result_ready && x == 1) begin
        abort = 1;
        hit = 1;
        break;
      end
      if (result_ready) pend = 1;
    end
    @(negedge clk);
    abort = 0; result_valid = 0;
    vecs++; if (hit !== 1'b1) begin errs++; $display("FAIL abort_reached: got %b want 1", hit); end
    vecs++; if (busy !== 1'b0 || done !== 1'b0 || result_ready !== 1'b0) begin
      errs++; $display("FAIL abort_idle: got busy=%b done=%b ready=%b want 0 0 0", busy, done, result_ready); end
    vecs++; if (sample_count !== 8'd1 || correct_count !== 8'd1) begin
      errs++; $display("FAIL abort_counts: got sc=%0d cc=%0d want 1 1", sample_count, correct_count); end
    vecs++; if (slot(1) !== 4'd0 || slot(0) !== 4'd1) begin
      errs++; $display("FAIL abort_slots: got s0=%0d s1=%0d want 1 0", slot(0), slot(1)); end
    vecs++; if (last_correct !== 8'd2) begin errs++; $display("FAIL abort_last_correct: got %0d want 2", last_correct); end
    abort = 1;
    @(negedge clk);
    abort = 0;
    vecs++; if (busy !== 1'b0 || done !== 1'b0 || sample_count !== 8'd1) begin
      errs++; $display("FAIL abort_in_idle: got busy=%b done=%b sc=%0d want 0 0 1", busy, done, sample_count); end
  endtask

  task automatic test_reset_mid_run;
    @(negedge clk);
    start = 1; mode = 0; num_samples = 4; result_valid = 0;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    vecs++; if (result_ready !== 1'b1) begin errs++; $display("FAIL mid_collect_ready: got %b want 1", result_ready); end
    result_valid = 1; result_data = 4'd1;
    @(negedge clk);
    result_valid = 0;
    @(negedge clk);
    vecs++; if (result_ready !== 1'b1 || sample_count !== 8'd1) begin
      errs++; $display("FAIL mid_before_reset: got ready=%b sc=%0d want 1 1", result_ready, sample_count); end
    #2 rstn = 0;
    #1;
    vecs++; if (busy !== 1'b0 || done !== 1'b0 || result_ready !== 1'b0) begin
      errs++; $display("FAIL async_reset_flags: got busy=%b done=%b ready=%b want 0 0 0", busy, done, result_ready); end
    vecs++; if (lcd_output !== 128'd0 || sample_count !== 8'd0 || correct_count !== 8'd0 || last_correct !== 8'd0 || exp_addr !== 8'd0) begin
      errs++; $display("FAIL async_reset_regs: got lcd=%h sc=%0d cc=%0d lc=%0d addr=%0d want all 0", lcd_output, sample_count, correct_count, last_correct, exp_addr); end
    @(negedge clk);
    rstn = 1;
    repeat (2) @(negedge clk);
    vecs++; if (busy !== 1'b0 || result_ready !== 1'b0 || sample_count !== 8'd0 || lcd_output !== 128'd0) begin
      errs++; $display("FAIL after_release: got busy=%b ready=%b sc=%0d lcd=%h want 0 0 0 0", busy, result_ready, sample_count, lcd_output); end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    for (int i = 0; i < 256; i++) rom[i] = 4'd0;
    for (int i = 0; i < 64; i++) res[i] = 4'd0;
    test_reset();
    test_single_pass();
    test_clamp();
    test_zero_samples();
    test_continuous();
    test_abort_transfer();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
